// File: rtl/shift_ctrl_pkg.sv
// rtl/shift_ctrl_pkg.sv - shared state encoding and parity sense for the serializer
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  localparam logic PARITY_SENSE = 1'b0;

endpackage

// File: rtl/shift_register_PISO.sv
// rtl/shift_register_PISO.sv - parallel-in serial-out shift register, MSB first
module shift_register_PISO #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         so
);

  logic [N-1:0] sreg;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[N-2:0], 1'b0};
    end
  end

  assign so = sreg[N-1];

endmodule

// File: rtl/shift_serializer_ctrl.sv
// rtl/shift_serializer_ctrl.sv - word-to-serial controller; PARITY_EN appends an even-parity bit
module shift_serializer_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic         SO,
  output logic         so_valid,
  output logic         sof,
  output logic         done,
  output logic         busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             shift_en;
  logic             msb;

  assign accept   = (state == S_IDLE) && din_valid;
  assign shift_en = (state == S_SHIFT);
  assign busy     = (state != S_IDLE);

  shift_register_PISO #(.N(N)) u_piso (
    .clk    (clk),
    .resetn (reset),
    .load   (accept),
    .shift  (shift_en),
    .din    (din),
    .so     (msb)
  );

`ifdef PARITY_EN
  // Parity is captured with the word so later din changes cannot disturb it.
  logic parity;

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= (^din) ^ PARITY_SENSE;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    din_ready = 1'b0;
    SO        = 1'b0;
    so_valid  = 1'b0;
    sof       = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = '0;
        end
      end
      S_SHIFT: begin
        SO       = msb;
        so_valid = 1'b1;
        sof      = (cnt == '0);
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          cnt_nxt = '0;
`ifdef PARITY_EN
          state_nxt = S_PARITY;
`else
          done      = 1'b1;
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        SO        = parity;
        so_valid  = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule
